// File: rtl/nibble_sort4_ctrl.sv
// Batch-of-four nibble sorter: loads four values, bubble-sorts them with one shared
// comparator (one compare per cycle, 9 fixed steps), then streams them out.
module comparator_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       a_gt_b,
    output logic       a_lt_b,
    output logic       a_eq_b
);
    assign a_gt_b = (a > b);
    assign a_lt_b = (a < b);
    assign a_eq_b = (a == b);
endmodule

module nibble_sort4_ctrl #(
    parameter bit DESCENDING = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       busy,
    output logic [2:0] swap_count
);
    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_SORT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      oidx_q, oidx_d;
    logic [3:0]      step_q, step_d;
    logic [2:0]      swap_cnt_q, swap_cnt_d;
    logic [3:0][3:0] entry_q, entry_d;

    logic [1:0] pair, pair_hi;
    logic [3:0] cmp_a, cmp_b;
    logic       a_gt_b, a_lt_b, a_eq_b, do_swap;

    // Three bubble passes over pairs (0,1),(1,2),(2,3) fully sort four entries.
    always_comb begin
        pair = 2'd2;
        case (step_q)
            4'd0, 4'd3, 4'd6: pair = 2'd0;
            4'd1, 4'd4, 4'd7: pair = 2'd1;
            default:          pair = 2'd2;
        endcase
        pair_hi = pair + 2'd1;
        cmp_a   = entry_q[pair];
        cmp_b   = entry_q[pair_hi];
    end

    comparator_4bit u_cmp (
        .a      (cmp_a),
        .b      (cmp_b),
        .a_gt_b (a_gt_b),
        .a_lt_b (a_lt_b),
        .a_eq_b (a_eq_b)
    );

    // Equal keys never swap, which keeps the sort stable.
    assign do_swap = !a_eq_b && (DESCENDING ? a_lt_b : a_gt_b);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        oidx_d     = oidx_q;
        step_d     = step_q;
        swap_cnt_d = swap_cnt_q;
        entry_d    = entry_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    entry_d[idx_q] = in_data;
                    idx_d          = idx_q + 2'd1;
                    if (idx_q == 2'd0) swap_cnt_d = 3'd0;
                    if (idx_q == 2'd3) begin
                        state_d = S_SORT;
                        step_d  = 4'd0;
                    end
                end
            end
            S_SORT: begin
                if (do_swap) begin
                    entry_d[pair]    = cmp_b;
                    entry_d[pair_hi] = cmp_a;
                    if (swap_cnt_q != 3'd6) swap_cnt_d = swap_cnt_q + 3'd1;
                end
                if (step_q == 4'd8) begin
                    state_d = S_DRAIN;
                    oidx_d  = 2'd0;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    oidx_d = oidx_q + 2'd1;
                    if (oidx_q == 2'd3) begin
                        state_d = S_LOAD;
                        idx_d   = 2'd0;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            idx_q      <= 2'd0;
            oidx_q     <= 2'd0;
            step_q     <= 4'd0;
            swap_cnt_q <= 3'd0;
            entry_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            oidx_q     <= oidx_d;
            step_q     <= step_d;
            swap_cnt_q <= swap_cnt_d;
            entry_q    <= entry_d;
        end
    end

    assign in_ready   = (state_q == S_LOAD);
    assign out_valid  = (state_q == S_DRAIN);
    assign busy       = (state_q == S_SORT) || (state_q == S_DRAIN);
    assign out_data   = out_valid ? entry_q[oidx_q] : 4'd0;
    assign swap_count = swap_cnt_q;
endmodule

// File: tb/tb_nibble_sort4_ctrl.sv
// Random and directed batches through ascending and descending instances, checked
// against a counting-sort / inversion-count reference model.
module tb_nibble_sort4_ctrl;
    typedef logic [3:0] batch_t [4];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       out_ready = 1'b0;

    logic       a_in_ready, a_out_valid, a_busy;
    logic [3:0] a_out_data;
    logic [2:0] a_swap;
    logic       d_in_ready, d_out_valid, d_busy;
    logic [3:0] d_out_data;
    logic [2:0] d_swap;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_sort4_ctrl #(.DESCENDING(1'b0)) u_asc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .busy(a_busy), .swap_count(a_swap)
    );

    nibble_sort4_ctrl #(.DESCENDING(1'b1)) u_dsc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
        .in_data(in_data), .out_valid(d_out_valid), .out_ready(out_ready),
        .out_data(d_out_data), .busy(d_busy), .swap_count(d_swap)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Sorted order via counting over the 16 key values; swaps of a full bubble sort
    // equal the number of strictly out-of-order pairs.
    function automatic void ref_model(input batch_t v, input bit desc,
                                      output batch_t o, output int inv);
        int n = 0;
        inv = 0;
        o = '{default: 4'd0};
        for (int k = 0; k < 16; k++) begin
            int key = desc ? 15 - k : k;
            for (int i = 0; i < 4; i++)
                if (int'(v[i]) == key) begin
                    o[n] = v[i];
                    n++;
                end
        end
        for (int i = 0; i < 4; i++)
            for (int k = i + 1; k < 4; k++)
                if (desc ? (v[i] < v[k]) : (v[i] > v[k])) inv++;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input int exp_a_swap, input int exp_d_swap);
        chk({tag, "_in_ready"}, int'(a_in_ready & d_in_ready), 1);
        chk({tag, "_out_valid"}, int'(a_out_valid | d_out_valid), 0);
        chk({tag, "_out_data"}, int'(a_out_data | d_out_data), 0);
        chk({tag, "_busy"}, int'(a_busy | d_busy), 0);
        chk({tag, "_swap_asc"}, int'(a_swap), exp_a_swap);
        chk({tag, "_swap_dsc"}, int'(d_swap), exp_d_swap);
    endtask

    task automatic load(input batch_t v);
        for (int i = 0; i < 4; i++) begin
            int gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                in_data  = 4'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data  = v[i];
            tick();
            in_valid = 1'b0;
            if (i == 0) begin
                chk("swap_clear_asc", int'(a_swap), 0);
                chk("swap_clear_dsc", int'(d_swap), 0);
            end
        end
    endtask

    task automatic run_batch(input batch_t v, input int stall_idx);
        batch_t ea, ed;
        int ia, id, lat;
        ref_model(v, 1'b0, ea, ia);
        ref_model(v, 1'b1, ed, id);
        load(v);
        chk("sort_in_ready", int'(a_in_ready | d_in_ready), 0);
        chk("sort_busy", int'(a_busy & d_busy), 1);
        // Producer keeps offering junk during SORT; it must be ignored.
        in_valid = 1'b1;
        in_data  = 4'($urandom);
        lat = 0;
        while (!a_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, 9);
        chk("dsc_valid_aligned", int'(d_out_valid), 1);
        for (int i = 0; i < 4; i++) begin
            int stalls = (i == stall_idx) ? 3 : int'($urandom_range(0, 2));
            for (int s = 0; s <= stalls; s++) begin
                out_ready = (s == stalls);
                chk("drain_valid", int'(a_out_valid & d_out_valid), 1);
                chk("drain_busy", int'(a_busy & d_busy), 1);
                chk("out_asc", int'(a_out_data), int'(ea[i]));
                chk("out_dsc", int'(d_out_data), int'(ed[i]));
                tick();
            end
            out_ready = 1'b0;
        end
        chk_idle("post", ia, id);
    endtask

    initial begin
        batch_t v;
        #2;
        chk_idle("reset", 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("after_reset", 0, 0);

        v = '{4'd9, 4'd3, 4'd15, 4'd0};
        run_batch(v, 1);
        chk("tp_swap_9_3_15_0", int'(a_swap), 4);
        chk("tp_swap_dsc_9_3_15_0", int'(d_swap), 2);
        v = '{4'd1, 4'd2, 4'd3, 4'd4};
        run_batch(v, -1);
        chk("tp_swap_sorted", int'(a_swap), 0);
        v = '{4'd15, 4'd10, 4'd5, 4'd0};
        run_batch(v, -1);
        chk("tp_swap_reversed", int'(a_swap), 6);
        v = '{4'd7, 4'd7, 4'd2, 4'd7};
        run_batch(v, 2);
        chk("tp_swap_dups", int'(a_swap), 2);

        // Reset while sorting: step 4 is reached four edges after the 4th accept.
        v = '{4'd5, 4'd12, 4'd1, 4'd9};
        load(v);
        for (int k = 0; k < 4; k++) tick();
        chk("pre_reset_busy", int'(a_busy), 1);
        rst_n = 1'b0;
        #1;
        chk_idle("mid_reset", 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("mid_reset_release", 0, 0);
        v = '{4'd8, 4'd1, 4'd4, 4'd2};
        run_batch(v, -1);

        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < 4; i++) v[i] = 4'($urandom);
            run_batch(v, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/nibble_sort4_ctrl.md
Name: nibble_sort4_ctrl

Overview:
Sequencing controller that collects a batch of four 4-bit values and sorts them in place. It uses a single shared comparator_4bit instance, one compare per cycle, then streams the sorted batch out. It sits between a 4-bit producer and consumer, both of which use valid/ready handshakes. It is the first block in the codebase that time-multiplexes the comparator instead of replicating it.

Parameters:
DESCENDING, 0, 0 = ascending output order; 1 = descending output order.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  producer has in_data
in_ready  output  1  block accepts a value this cycle
in_data  input  4  value to load
out_valid  output  1  out_data holds a sorted element
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  4  sorted element, index 0 first
busy  output  1  high in SORT and DRAIN
swap_count  output  3  swaps performed in the last or current sort (0..6)

Behaviour:
- Reset (rst_n low, async): state LOAD, load index 0, all four entry regs 0, out_valid 0, out_data 0, busy 0, swap_count 0. in_ready = (state==LOAD), so it reads 1 during and after reset.
- Reset mid-operation: the batch is discarded and the block returns to LOAD with index 0. There is no partial output.
- The FSM has three states: LOAD, SORT and DRAIN.
- LOAD:
  - in_ready=1. Each in_valid&in_ready edge writes in_data to entry[idx], then idx++.
  - The first accepted value of a batch clears swap_count.
  - Acceptance of the 4th value moves the FSM to SORT and clears the step counter.
- SORT:
  - in_ready=0, busy=1. There are exactly 9 cycles: step s = 0..8, pair j = s mod 3, with A=entry[j] and B=entry[j+1] fed to the comparator.
  - Swap condition: A_gt_B when DESCENDING=0, A_lt_B when DESCENDING=1. A_eq_B never swaps, so the sort is stable.
  - A swap exchanges entry[j] and entry[j+1] at the clock edge and increments swap_count (saturating at 6, which cannot be exceeded).
  - After step 8 the FSM moves to DRAIN with output index 0.
- Latency: if the 4th value is accepted at edge T, out_valid rises after edge T+9, i.e. 9 full SORT cycles. The latency does not depend on the data.
- DRAIN:
  - out_valid=1, out_data=entry[oidx], busy=1, in_ready=0.
  - On out_valid&out_ready, oidx++.
  - While out_ready=0, out_data and out_valid hold stable.
  - After the handshake with oidx=3: out_valid drops, the FSM returns to LOAD, and in_ready=1 on the next cycle. There is no overlap between batches.
- swap_count holds its final value through DRAIN and LOAD until the first value of the next batch is accepted.
- Width rules: the comparison is unsigned 4-bit (0..15) and there is no arithmetic on the data. idx/oidx are 2 bits and the step counter is 4 bits.
- in_valid during SORT or DRAIN is ignored, since in_ready=0. out_ready is ignored outside DRAIN.

Test Plan:
- Load 9,3,15,0 with DESCENDING=0 -> out 0,3,9,15; swap_count=4; out_valid first high 9 cycles after the 4th input edge.
- Load 1,2,3,4 -> out 1,2,3,4; swap_count=0; same 9-cycle latency.
- Load 15,10,5,0 -> out 0,5,10,15; swap_count=6. Load 7,7,2,7 -> out 2,7,7,7; swap_count=2.
- Hold out_ready low for 3 cycles after element 1 -> out_data stays 3 and out_valid stays high for the whole stall; the remaining elements then drain in order; in_ready=1 on the cycle after the final handshake.
- Assert rst_n low at SORT step 4 -> outputs go to reset values immediately; a new batch 8,1,4,2 then sorts to 1,2,4,8 correctly.
- With DESCENDING=1, load 9,3,15,0 -> out 15,9,3,0; swap_count=2.
